// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and scan-image classification for the keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int IMG_W    = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAND    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REL     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } scan_class_t;

    function automatic scan_class_t classify_scan(input logic [IMG_W-1:0] img);
        int unsigned n;
        n = 0;
        for (int i = 0; i < IMG_W; i++) begin
            n += 32'(img[i]);
        end
        if (n == 0) begin
            return CLS_NONE;
        end
        if (n == 1) begin
            return CLS_SINGLE;
        end
        return CLS_MULTI;
    endfunction

    // Only meaningful when exactly one bit is set; returns the lowest set index.
    function automatic logic [3:0] lowest_set(input logic [IMG_W-1:0] img);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = IMG_W - 1; i >= 0; i--) begin
            if (img[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - scan-rate debounce FSM that accepts single key presses and releases
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        hwclk,
    input  logic        rst,
    input  logic        scan_end,
    input  scan_class_t scan_class,
    input  logic [3:0]  k,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down
);

    localparam logic [3:0] TARGET = 4'(DEBOUNCE_SCANS);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n, cnt_inc;
    logic [3:0] cand, cand_n;
    logic [3:0] code_n;
    logic       valid_n, down_n, accept;

    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= down_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = key_code;
        valid_n = 1'b0;
        down_n  = key_down;
        accept  = 1'b0;
        if (scan_end) begin
            unique case (state)
                ST_IDLE: begin
                    if (scan_class == CLS_SINGLE) begin
                        cand_n = k;
                        cnt_n  = 4'd1;
                        if (TARGET <= 4'd1) begin
                            accept = 1'b1;
                        end else begin
                            state_n = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (scan_class == CLS_SINGLE && k == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= TARGET) begin
                            accept = 1'b1;
                        end
                    end else if (scan_class == CLS_SINGLE) begin
                        cand_n = k;
                        cnt_n  = 4'd1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = 4'd0;
                    end
                end
                ST_PRESSED: begin
                    if (scan_class == CLS_NONE) begin
                        cnt_n = 4'd1;
                        if (TARGET <= 4'd1) begin
                            state_n = ST_IDLE;
                            down_n  = 1'b0;
                            cnt_n   = 4'd0;
                        end else begin
                            state_n = ST_REL;
                        end
                    end
                end
                ST_REL: begin
                    if (scan_class == CLS_NONE) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= TARGET) begin
                            state_n = ST_IDLE;
                            down_n  = 1'b0;
                            cnt_n   = 4'd0;
                        end
                    end else begin
                        state_n = ST_PRESSED;
                        cnt_n   = 4'd0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end
            endcase
        end
        // Acceptance is shared by the direct IDLE path and the counted CAND path.
        if (accept) begin
            state_n = ST_PRESSED;
            code_n  = cand_n;
            valid_n = 1'b1;
            down_n  = 1'b1;
            cnt_n   = 4'd0;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with column synchronizer, scan image and debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic [3:0] keypad_c,
    output logic [3:0] keypad_r,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0]    dwell;
    logic [1:0]       row;
    logic [3:0]       c_meta, c_sync;
    logic [IMG_W-1:0] image, image_next;
    logic             tc, scan_end;
    scan_class_t      scan_class;
    logic [3:0]       scan_k;

    assign tc       = (dwell == DW'(SCAN_DIV - 1));
    assign scan_end = tc && (row == 2'(NUM_ROWS - 1));
    assign keypad_r = ~(4'b0001 << row);

    // Columns are inverted on entry so the synchronizer and image use 1 = pressed.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            c_meta <= 4'd0;
            c_sync <= 4'd0;
            dwell  <= '0;
            row    <= 2'd0;
            image  <= '0;
        end else begin
            c_meta <= ~keypad_c;
            c_sync <= c_meta;
            if (tc) begin
                dwell <= '0;
                row   <= row + 2'd1;
                image <= image_next;
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // The current row's slot is filled at terminal count, so the scan-end result includes row 3.
    always_comb begin
        image_next = image;
        image_next[{row, 2'b00} +: NUM_COLS] = c_sync;
    end

    assign scan_class = classify_scan(image_next);
    assign scan_k     = lowest_set(image_next);

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .hwclk     (hwclk),
        .rst       (rst),
        .scan_end  (scan_end),
        .scan_class(scan_class),
        .k         (scan_k),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a physical keypad model
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 2;
    localparam int SCAN_CYC = SCAN_DIV * 4;

    logic        hwclk;
    logic        rst;
    logic [3:0]  keypad_c;
    logic [3:0]  keypad_r;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] matrix;

    int checks;
    int errors;

    bit         held;
    int         run_len;
    int         run_k;
    logic [3:0] m_code;
    bit         pend_valid;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .hwclk    (hwclk),
        .rst      (rst),
        .keypad_c (keypad_c),
        .keypad_r (keypad_r),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    // A closed key pulls its column low only while its row is driven low.
    function automatic logic [3:0] col_lines(input logic [15:0] m, input logic [3:0] r);
        logic [3:0] c;
        c = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                if (!r[rr] && m[rr*4+cc]) begin
                    c[cc] = 1'b0;
                end
            end
        end
        return c;
    endfunction

    always_comb keypad_c = col_lines(matrix, keypad_r);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        held       = 1'b0;
        run_len    = 0;
        run_k      = 0;
        m_code     = 4'd0;
        pend_valid = 1'b0;
    endtask

    // Run-length view: a press needs DS consecutive identical single-key scans,
    // a release needs DS consecutive empty scans.
    task automatic model_scan(input logic [15:0] m);
        int pc;
        int k;
        pc = 0;
        k  = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                pc++;
                k = i;
            end
        end
        pend_valid = 1'b0;
        if (!held) begin
            if (pc == 1) begin
                if (run_len > 0 && run_k == k) begin
                    run_len++;
                end else begin
                    run_len = 1;
                    run_k   = k;
                end
                if (run_len >= DS) begin
                    held       = 1'b1;
                    m_code     = 4'(k);
                    pend_valid = 1'b1;
                    run_len    = 0;
                end
            end else begin
                run_len = 0;
            end
        end else begin
            if (pc == 0) begin
                run_len++;
                if (run_len >= DS) begin
                    held    = 1'b0;
                    run_len = 0;
                end
            end else begin
                run_len = 0;
            end
        end
    endtask

    task automatic run_scan(input logic [15:0] m);
        logic [3:0] er;
        matrix = m;
        for (int t = 0; t < SCAN_CYC; t++) begin
            er = 4'b0001 << (t / SCAN_DIV);
            er = ~er;
            check("keypad_r", {12'd0, keypad_r}, {12'd0, er});
            check("key_valid", {15'd0, key_valid}, {15'd0, (t == 0) ? pend_valid : 1'b0});
            check("key_down", {15'd0, key_down}, {15'd0, held});
            check("key_code", {12'd0, key_code}, {12'd0, m_code});
            @(negedge hwclk);
        end
        model_scan(m);
    endtask

    task automatic run_scans(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            run_scan(m);
        end
    endtask

    task automatic reset_mid();
        @(posedge hwclk);
        #2 rst = 1'b1;
        #1;
        check("rst_key_down", {15'd0, key_down}, 16'd0);
        check("rst_keypad_r", {12'd0, keypad_r}, 16'h000E);
        check("rst_key_valid", {15'd0, key_valid}, 16'd0);
        check("rst_key_code", {12'd0, key_code}, 16'd0);
        repeat (3) @(posedge hwclk);
        @(negedge hwclk);
        rst = 1'b0;
        model_reset();
    endtask

    localparam logic [15:0] KEY9 = 16'h0200;
    localparam logic [15:0] TWO  = 16'h0041;

    initial begin
        logic [15:0] m;
        int kind, a, b, n;
        checks = 0;
        errors = 0;
        matrix = 16'd0;
        rst    = 1'b1;
        model_reset();
        repeat (3) @(negedge hwclk);
        check("reset_keypad_r", {12'd0, keypad_r}, 16'h000E);
        check("reset_key_down", {15'd0, key_down}, 16'd0);
        rst = 1'b0;

        run_scans(16'd0, 3);
        run_scans(KEY9, 3);
        run_scans(16'd0, 2);
        run_scan(KEY9);
        run_scans(16'd0, 2);
        run_scans(TWO, 4);
        run_scans(16'd0, 1);
        run_scans(KEY9, 3);
        run_scans(16'd0, 1);
        run_scans(KEY9, 2);
        check("pressed_before_reset", {15'd0, key_down}, 16'd1);
        reset_mid();
        run_scans(KEY9, 3);
        run_scans(16'd0, 2);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            n    = $urandom_range(1, 3);
            m    = 16'd0;
            if (kind == 1 || kind == 2) begin
                m[a] = 1'b1;
            end else if (kind == 3) begin
                m[a] = 1'b1;
                m[b] = 1'b1;
            end
            run_scans(m, n);
        end
        run_scans(16'd0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
